// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    RELEASE,
    DONE
  } seq_state_e;

  localparam int RST_CNT_W = 8;
  localparam logic [RST_CNT_W-1:0] RST_CNT_MAX = 8'd255;

  // Width of the interval counter: wide enough for the longer of hold and gap.
  function automatic int cnt_width(input int hold_cyc, input int gap_cyc);
    int longest;
    longest = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Request/status bundle between the reset sequencer and its environment.
interface rst_seq_if
  import rst_seq_pkg::*;
#(
  parameter int N_CH = 4
);

  logic                 ext_rst_n;
  logic                 soft_rst_req;
  logic [N_CH-1:0]      ch_rst_n;
  logic                 seq_busy;
  logic                 seq_done;
  logic [RST_CNT_W-1:0] rst_count;

  modport master (
    output ext_rst_n, soft_rst_req,
    input  ch_rst_n, seq_busy, seq_done, rst_count
  );

  modport slave (
    input  ext_rst_n, soft_rst_req,
    output ch_rst_n, seq_busy, seq_done, rst_count
  );

endinterface

// File: rtl/rst_seq_sync_bit.sv
// Single-bit flop-chain synchroniser with synchronous active-low reset.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the chain; reset parks it at RST_VAL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: asserts all channel resets together, then releases them
// one by one in index order after a hold interval, spaced by a gap interval.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int HOLD_CYC    = 16,
  parameter int GAP_CYC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  rst_seq_if.slave bus
);

  localparam int CNT_W = cnt_width(HOLD_CYC, GAP_CYC);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  seq_state_e           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [N_CH-1:0]      ch_mask;
  logic                 busy;
  logic                 done;
  logic [RST_CNT_W-1:0] count;
  logic                 req_last;
  logic                 ext_sync;
  logic                 req;

  sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_ext_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (bus.ext_rst_n),
    .q     (ext_sync)
  );

  assign req = bus.soft_rst_req | ~ext_sync;

  // Sequencer FSM; every output is a flop, restart requests override counting.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= ASSERT;
      cnt      <= '0;
      idx      <= '0;
      ch_mask  <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
      count    <= '0;
      req_last <= 1'b0;
    end else begin
      req_last <= req;
      done     <= 1'b0;
      // A held request counts once; the counter sticks at its maximum.
      if (req && !req_last && (count != RST_CNT_MAX)) begin
        count <= count + RST_CNT_W'(1);
      end
      if (req) begin
        state   <= ASSERT;
        cnt     <= '0;
        idx     <= '0;
        ch_mask <= '0;
        busy    <= 1'b1;
      end else begin
        case (state)
          ASSERT: begin
            if (cnt == CNT_W'(HOLD_CYC - 1)) begin
              cnt        <= '0;
              ch_mask[0] <= 1'b1;
              if (N_CH == 1) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= RELEASE;
                idx   <= IDX_W'(1);
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          RELEASE: begin
            if (cnt == CNT_W'(GAP_CYC - 1)) begin
              cnt          <= '0;
              ch_mask[idx] <= 1'b1;
              idx          <= idx + IDX_W'(1);
              if (idx == IDX_W'(N_CH - 1)) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= DONE;
          end
        endcase
      end
    end
  end

  assign bus.ch_rst_n  = ch_mask;
  assign bus.seq_busy  = busy;
  assign bus.seq_done  = done;
  assign bus.rst_count = count;

endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq: scripted vector table, hand-written corner cases and
// a randomized run, all checked against a cycle-level timing model.
module tb_rst_seq;

  localparam int N_CH        = 4;
  localparam int HOLD_CYC    = 16;
  localparam int GAP_CYC     = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MAXC        = 8192;

  logic clk;
  logic rst_n;

  rst_seq_if #(.N_CH(N_CH)) bus_if ();

  rst_seq #(
    .N_CH        (N_CH),
    .HOLD_CYC    (HOLD_CYC),
    .GAP_CYC     (GAP_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus_if)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic rst_h [MAXC];
  logic ext_h [MAXC];

  logic [N_CH-1:0] smp_ch;
  logic            smp_busy;
  logic            smp_done;
  logic [7:0]      smp_cnt;

  // Model state: last cycle that blocked counting, restart count, previous req.
  int   last_blk = 0;
  int   m_cnt    = 0;
  logic m_prev   = 1'b0;
  logic have_rst = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Synchronised ext_rst_n as seen by the sequencer in cycle n.
  function automatic logic sync_at(input int n);
    for (int j = 1; j <= SYNC_STAGES; j++) begin
      if (n - j < 0) return 1'b1;
      if (!rst_h[n - j]) return 1'b1;
    end
    return ext_h[n - SYNC_STAGES];
  endfunction

  task automatic model_check();
    int t;
    logic [N_CH-1:0] e_ch;
    logic e_done;
    if (have_rst) begin
      t = last_blk + 1;
      for (int k = 0; k < N_CH; k++) e_ch[k] = (cyc >= t + HOLD_CYC + k * GAP_CYC);
      e_done = (cyc == t + HOLD_CYC + (N_CH - 1) * GAP_CYC);
      chk("model_ch_rst_n", 32'(smp_ch), 32'(e_ch));
      chk("model_seq_busy", 32'(smp_busy), 32'(~&e_ch));
      chk("model_seq_done", 32'(smp_done), 32'(e_done));
      chk("model_rst_count", 32'(smp_cnt), 32'(m_cnt));
    end
  endtask

  task automatic model_advance(input logic r, input logic s);
    logic req;
    req = s | ~sync_at(cyc);
    if (!r) begin
      m_cnt    = 0;
      m_prev   = 1'b0;
      have_rst = 1'b1;
      last_blk = cyc;
    end else begin
      if (req && !m_prev && m_cnt < 255) m_cnt++;
      m_prev = req;
      if (req) last_blk = cyc;
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, check model, advance.
  task automatic step(input logic r, input logic e, input logic s);
    rst_n               = r;
    bus_if.ext_rst_n    = e;
    bus_if.soft_rst_req = s;
    rst_h[cyc] = r;
    ext_h[cyc] = e;
    @(negedge clk);
    smp_ch   = bus_if.ch_rst_n;
    smp_busy = bus_if.seq_busy;
    smp_done = bus_if.seq_done;
    smp_cnt  = bus_if.rst_count;
    model_check();
    model_advance(r, s);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    int         cyc;
    logic       rn;
    logic       e;
    logic       s;
    logic       chk;
    logic [3:0] ch;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int c, input logic rn, input logic e, input logic s, input logic ck,
                     input logic [3:0] ch, input logic busy, input logic done, input logic [7:0] cnt);
    vec_t v;
    v = '{c, rn, e, s, ck, ch, busy, done, cnt};
    vt.push_back(v);
  endtask

  initial begin
    int ptr;
    int a;
    logic cur_r, cur_e, cur_s;
    int exp_cnt;
    int rst_left;
    logic ext_lvl;

    rst_n = 1'b0;
    bus_if.ext_rst_n = 1'b1;
    bus_if.soft_rst_req = 1'b0;

    // Scenarios 1-3: inputs in a row hold until the next row.
    add(0,   0, 1, 0, 0, 4'b0000, 1, 0, 0);
    add(1,   0, 1, 0, 1, 4'b0000, 1, 0, 0);
    add(2,   0, 1, 0, 1, 4'b0000, 1, 0, 0);
    add(3,   1, 1, 0, 1, 4'b0000, 1, 0, 0);
    add(18,  1, 1, 0, 1, 4'b0000, 1, 0, 0);
    add(19,  1, 1, 0, 1, 4'b0001, 1, 0, 0);
    add(27,  1, 1, 0, 1, 4'b0011, 1, 0, 0);
    add(35,  1, 1, 0, 1, 4'b0111, 1, 0, 0);
    add(42,  1, 1, 0, 1, 4'b0111, 1, 0, 0);
    add(43,  1, 1, 0, 1, 4'b1111, 0, 1, 0);
    add(44,  1, 1, 0, 1, 4'b1111, 0, 0, 0);
    add(100, 1, 1, 1, 1, 4'b1111, 0, 0, 0);
    add(101, 1, 1, 0, 1, 4'b0000, 1, 0, 1);
    add(116, 1, 1, 0, 1, 4'b0000, 1, 0, 1);
    add(117, 1, 1, 0, 1, 4'b0001, 1, 0, 1);
    add(140, 1, 1, 0, 1, 4'b0111, 1, 0, 1);
    add(141, 1, 1, 0, 1, 4'b1111, 0, 1, 1);
    add(142, 1, 1, 0, 1, 4'b1111, 0, 0, 1);
    add(200, 1, 0, 0, 1, 4'b1111, 0, 0, 1);
    add(202, 1, 0, 0, 1, 4'b1111, 0, 0, 1);
    add(203, 1, 0, 0, 1, 4'b0000, 1, 0, 2);
    add(210, 1, 1, 0, 1, 4'b0000, 1, 0, 2);
    add(211, 1, 1, 0, 1, 4'b0000, 1, 0, 2);
    add(227, 1, 1, 0, 1, 4'b0000, 1, 0, 2);
    add(228, 1, 1, 0, 1, 4'b0001, 1, 0, 2);
    add(252, 1, 1, 0, 1, 4'b1111, 0, 1, 2);
    add(253, 1, 1, 0, 1, 4'b1111, 0, 0, 2);

    ptr = 0;
    cur_r = 1'b0; cur_e = 1'b1; cur_s = 1'b0;
    for (int c = 0; c < 260; c++) begin
      int row;
      row = -1;
      if (ptr < vt.size() && vt[ptr].cyc == c) begin
        row = ptr;
        cur_r = vt[ptr].rn; cur_e = vt[ptr].e; cur_s = vt[ptr].s;
        ptr++;
      end
      step(cur_r, cur_e, cur_s);
      if (row >= 0 && vt[row].chk) begin
        chk("vec_ch_rst_n", 32'(smp_ch), 32'(vt[row].ch));
        chk("vec_seq_busy", 32'(smp_busy), 32'(vt[row].busy));
        chk("vec_seq_done", 32'(smp_done), 32'(vt[row].done));
        chk("vec_rst_count", 32'(smp_cnt), 32'(vt[row].cnt));
      end
    end

    // Scenario 4: restart the cycle after ch1 releases.
    a = cyc;
    step(1, 1, 1);
    for (int i = 1; i <= 25; i++) begin
      step(1, 1, 0);
      if (i == 24) chk("mid_ch0_only", 32'(smp_ch), 32'b0001);
      if (i == 25) chk("mid_ch1_rel", 32'(smp_ch), 32'b0011);
    end
    step(1, 1, 1);
    for (int i = 0; i <= 40; i++) begin
      step(1, 1, 0);
      if (i == 0) begin
        chk("mid_reassert", 32'(smp_ch), 32'b0000);
        chk("mid_busy", 32'(smp_busy), 32'b1);
      end
      if (i < 40) chk("mid_no_done", 32'(smp_done), 32'b0);
      if (i == 15) chk("mid_hold", 32'(smp_ch), 32'b0000);
      if (i == 16) chk("mid_ch0", 32'(smp_ch), 32'b0001);
      if (i == 24) chk("mid_ch1", 32'(smp_ch), 32'b0011);
      if (i == 40) begin
        chk("mid_ch3", 32'(smp_ch), 32'b1111);
        chk("mid_done", 32'(smp_done), 32'b1);
      end
    end

    // Scenario 5: held request counts once, then saturation.
    exp_cnt = m_cnt + 1;
    for (int i = 0; i < 5; i++) step(1, 1, 1);
    step(1, 1, 0);
    chk("held_req_count", 32'(smp_cnt), 32'(exp_cnt));
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 1);
      step(1, 1, 0);
    end
    step(1, 1, 0);
    chk("count_saturate", 32'(smp_cnt), 32'd255);

    // Scenario 6: reset coinciding with soft request.
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i <= 44; i++) begin
      step(1, 1, 0);
      if (i == 0) begin
        chk("prio_count", 32'(smp_cnt), 32'd0);
        chk("prio_ch", 32'(smp_ch), 32'b0000);
      end
      if (i == 15) chk("prio_hold", 32'(smp_ch), 32'b0000);
      if (i == 16) chk("prio_ch0", 32'(smp_ch), 32'b0001);
      if (i == 40) begin
        chk("prio_ch3", 32'(smp_ch), 32'b1111);
        chk("prio_done", 32'(smp_done), 32'b1);
      end
      if (i == 44) chk("prio_count_end", 32'(smp_cnt), 32'd0);
    end

    // Randomized traffic against the model.
    rst_left = 0;
    ext_lvl  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic s;
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(0, 249) == 0) rst_left = $urandom_range(1, 3);
      if (ext_lvl && $urandom_range(0, 149) == 0) ext_lvl = 1'b0;
      else if (!ext_lvl && $urandom_range(0, 5) == 0) ext_lvl = 1'b1;
      s = ($urandom_range(0, 59) == 0);
      step(rst_left == 0, ext_lvl, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
